// File: rtl/demux_nbit_1to4_reg.sv
// Registered 1-to-4 stream demultiplexer: each accepted word lands in the
// one-entry holding register of the channel picked by in_sel.
module demux_nbit_1to4_reg #(
    parameter int N = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [1:0]   in_sel,
    input  logic [N-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [N-1:0] out_data_a,
    output logic [N-1:0] out_data_b,
    output logic [N-1:0] out_data_c,
    output logic [N-1:0] out_data_d,
    output logic [3:0]   out_valid,
    input  logic [3:0]   out_ready,
    output logic         busy
);

    logic [N-1:0] data_q [4];
    logic [N-1:0] data_d [4];
    logic [3:0]   valid_q;
    logic [3:0]   valid_d;
    logic         accept;

    // A full target channel can still take a word if its consumer drains it
    // in the same cycle, giving full-rate pass-through.
    assign in_ready = !rst && (!valid_q[in_sel] || out_ready[in_sel]);
    assign accept   = in_valid && in_ready;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_chan
            logic load;
            logic drain;

            assign load  = accept && (in_sel == 2'(gi));
            assign drain = valid_q[gi] && out_ready[gi];

            assign valid_d[gi] = load || (valid_q[gi] && !drain);
            assign data_d[gi]  = load ? in_data : data_q[gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            for (int i = 0; i < 4; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            for (int i = 0; i < 4; i++) begin
                data_q[i] <= data_d[i];
            end
        end
    end

    assign out_data_a = data_q[0];
    assign out_data_b = data_q[1];
    assign out_data_c = data_q[2];
    assign out_data_d = data_q[3];
    assign out_valid  = valid_q;
    assign busy       = |valid_q;

endmodule

// File: tb/tb_demux_nbit_1to4_reg.sv
// Bench for demux_nbit_1to4_reg: per-channel queue scoreboard checked every
// cycle, plus directed scenarios with literal expectations.
module tb_demux_nbit_1to4_reg;
    localparam int N = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [1:0]   in_sel = 2'd0;
    logic [N-1:0] in_data = '0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [N-1:0] out_data_a, out_data_b, out_data_c, out_data_d;
    logic [3:0]   out_valid;
    logic [3:0]   out_ready = 4'b0000;
    logic         busy;

    demux_nbit_1to4_reg #(.N(N)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_sel     (in_sel),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_data_a (out_data_a),
        .out_data_b (out_data_b),
        .out_data_c (out_data_c),
        .out_data_d (out_data_d),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Model: each channel is a queue of pending words; hold[] is what the
    // channel's output register shows (last word loaded, 0 after reset).
    logic [N-1:0] q [4][$];
    logic [N-1:0] hold [4];
    bit           started = 1'b0;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit model_in_ready();
        return !rst && (q[in_sel].size() == 0 || out_ready[in_sel]);
    endfunction

    function automatic logic [N-1:0] dut_data(int ch);
        case (ch)
            0:       return out_data_a;
            1:       return out_data_b;
            2:       return out_data_c;
            default: return out_data_d;
        endcase
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            started = 1'b1;
            for (int ch = 0; ch < 4; ch++) begin
                q[ch].delete();
                hold[ch] = '0;
            end
        end else if (started) begin
            bit           acc;
            logic [1:0]   s;
            logic [N-1:0] w;
            acc = in_valid && model_in_ready();
            s   = in_sel;
            w   = in_data;
            for (int ch = 0; ch < 4; ch++) begin
                if (q[ch].size() > 0 && out_ready[ch]) void'(q[ch].pop_front());
            end
            if (acc) begin
                q[s].push_back(w);
                hold[s] = w;
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            logic [3:0] ev;
            for (int ch = 0; ch < 4; ch++) begin
                ev[ch] = (q[ch].size() > 0);
                check($sformatf("data_ch%0d", ch), 32'(dut_data(ch)), 32'(hold[ch]));
                if (q[ch].size() > 0)
                    check($sformatf("order_ch%0d", ch), 32'(dut_data(ch)), 32'(q[ch][0]));
            end
            check("out_valid", 32'(out_valid), 32'(ev));
            check("busy", 32'(busy), 32'(|ev));
            check("in_ready", 32'(in_ready), 32'(model_in_ready()));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(logic [1:0] s, logic [N-1:0] d);
        in_valid = 1'b1;
        in_sel   = s;
        in_data  = d;
        step();
    endtask

    initial begin
        rst = 1'b1;
        step();
        step();
        check("rst_in_ready", 32'(in_ready), 32'h0);
        check("rst_out_valid", 32'(out_valid), 32'h0);
        check("rst_data_a", 32'(out_data_a), 32'h0);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", 32'(in_ready), 32'h1);

        // Reset then route
        send(2'd0, 8'h11);
        send(2'd1, 8'h22);
        send(2'd2, 8'h33);
        send(2'd3, 8'h44);
        in_sel = 2'd1; in_data = 8'h55;
        #1;
        check("route_fifth_in_ready", 32'(in_ready), 32'h0);
        check("route_out_valid", 32'(out_valid), 32'hF);
        check("route_data_d", 32'(out_data_d), 32'h44);
        check("route_data_b", 32'(out_data_b), 32'h22);
        check("route_busy", 32'(busy), 32'h1);
        in_valid = 1'b0;

        // Select mapping
        rst = 1'b1;
        step();
        rst = 1'b0;
        send(2'd1, 8'hA5);
        in_valid = 1'b0;
        check("sel_out_valid", 32'(out_valid), 32'h2);
        check("sel_data_b", 32'(out_data_b), 32'hA5);
        check("sel_data_d", 32'(out_data_d), 32'h0);

        // Backpressure isolation: c full and stalled, a draining
        send(2'd2, 8'h77);
        out_ready = 4'b0001;
        for (int i = 1; i <= 3; i++) begin
            in_valid = 1'b1; in_sel = 2'd0; in_data = 8'(i);
            #1;
            check("iso_in_ready_a", 32'(in_ready), 32'h1);
            step();
        end
        in_sel = 2'd2; in_data = 8'h99;
        #1;
        check("iso_in_ready_c", 32'(in_ready), 32'h0);
        check("iso_data_c", 32'(out_data_c), 32'h77);
        check("iso_data_a", 32'(out_data_a), 32'h03);
        in_valid = 1'b0;

        // Full-rate pass-through on channel a
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1; in_sel = 2'd0; in_data = 8'(8'h90 + i);
            #1;
            check("pt_in_ready", 32'(in_ready), 32'h1);
            if (i > 0) begin
                check("pt_valid_a", 32'(out_valid[0]), 32'h1);
                check("pt_data_a", 32'(out_data_a), 32'(8'h90 + i - 1));
            end
            step();
        end
        in_valid = 1'b0;
        check("pt_last_a", 32'(out_data_a), 32'h95);

        // Reset mid-stream with an input presented
        out_ready = 4'b0000;
        rst = 1'b1;
        step();
        rst = 1'b0;
        send(2'd0, 8'hB1);
        send(2'd1, 8'hB2);
        check("mid_pre_valid", 32'(out_valid), 32'h3);
        rst = 1'b1; in_valid = 1'b1; in_sel = 2'd2; in_data = 8'hCC;
        #1;
        check("mid_rst_in_ready", 32'(in_ready), 32'h0);
        step();
        rst = 1'b0; in_valid = 1'b0;
        check("mid_out_valid", 32'(out_valid), 32'h0);
        check("mid_data_a", 32'(out_data_a), 32'h0);
        check("mid_data_c", 32'(out_data_c), 32'h0);

        // Random soak; producer holds its word while stalled
        for (int c = 0; c < 10000; c++) begin
            if (!(in_valid && !in_ready)) begin
                in_valid = 1'($urandom_range(0, 1));
                in_sel   = 2'($urandom_range(0, 3));
                in_data  = 8'($urandom);
            end
            out_ready = 4'($urandom);
            step();
        end
        in_valid  = 1'b0;
        out_ready = 4'b1111;
        step();
        step();
        check("drain_out_valid", 32'(out_valid), 32'h0);
        check("drain_busy", 32'(busy), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
